// File: rtl/lavanderia_param.sv
// Coin-operated laundry payment FSM; optional change return under LAVANDERIA_VUELTO_EN.
// Latency: service/insuficiente output rises two edges after finalizar_pago is sampled.
// Backpressure: none; coins and requests arriving while busy are ignored.
module lavanderia_param #(
    parameter int CNT_W     = 4,
    parameter int PRICE_SEC = 3,
    parameter int PRICE_LAV = 4,
    parameter int PRICE_PES = 9,
    parameter int T_SEC     = 3,
    parameter int T_LAV     = 4,
    parameter int T_PES     = 9,
    parameter int T_INS     = 1,
    parameter int TIMEOUT   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             intro_moneda,
    input  logic             finalizar_pago,
    input  logic             cancelar,
    output logic             SECADO,
    output logic             LAVADO,
    output logic             LAVADO_PESADO,
    output logic             insuficiente,
    output logic             ocupado,
    output logic [CNT_W-1:0] monedas,
    output logic [CNT_W-1:0] vuelto
);

    localparam int T_M1  = (T_SEC > T_LAV) ? T_SEC : T_LAV;
    localparam int T_M2  = (T_M1 > T_PES) ? T_M1 : T_PES;
    localparam int T_M3  = (T_M2 > T_INS) ? T_M2 : T_INS;
    localparam int T_MAX = (T_M3 > TIMEOUT) ? T_M3 : TIMEOUT;
    localparam int TMR_W = $clog2(T_MAX + 1);

    localparam logic [CNT_W-1:0] P_SEC = CNT_W'(PRICE_SEC);
    localparam logic [CNT_W-1:0] P_LAV = CNT_W'(PRICE_LAV);
    localparam logic [CNT_W-1:0] P_PES = CNT_W'(PRICE_PES);

    // Timer holds "cycles remaining minus one" while a pulse is active.
    localparam logic [TMR_W-1:0] D_SEC   = TMR_W'(T_SEC - 1);
    localparam logic [TMR_W-1:0] D_LAV   = TMR_W'(T_LAV - 1);
    localparam logic [TMR_W-1:0] D_PES   = TMR_W'(T_PES - 1);
    localparam logic [TMR_W-1:0] D_INS   = TMR_W'(T_INS - 1);
    localparam logic [TMR_W-1:0] TMO_END = TMR_W'(TIMEOUT - 1);

    if (PRICE_SEC == PRICE_LAV || PRICE_SEC == PRICE_PES || PRICE_LAV == PRICE_PES ||
        PRICE_SEC <= 0 || PRICE_LAV <= 0 || PRICE_PES <= 0 ||
        PRICE_SEC >= (1 << CNT_W) || PRICE_LAV >= (1 << CNT_W) || PRICE_PES >= (1 << CNT_W))
    begin : g_bad_price
        $fatal(1, "lavanderia_param: prices must be distinct, nonzero and fit in CNT_W bits");
    end

    if (T_SEC < 1 || T_LAV < 1 || T_PES < 1 || T_INS < 1 || TIMEOUT < 2) begin : g_bad_time
        $fatal(1, "lavanderia_param: pulse lengths must be >= 1 and TIMEOUT >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNTING,
        S_VERIFY,
        S_SERVICE,
        S_REJECT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [2:0]       svc_q, svc_d;   // {PES, LAV, SEC}, one-hot or zero
    logic             ins_q, ins_d;
    logic             ocu_q, ocu_d;

    logic [2:0]       sel;
    logic [TMR_W-1:0] sel_dur;
    logic [CNT_W-1:0] cnt_inc;

`ifdef LAVANDERIA_VUELTO_EN
    logic [CNT_W-1:0] vuelto_q, vuelto_d;
    logic [CNT_W-1:0] best;
    logic [CNT_W-1:0] sel_chg;
`endif

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        sel     = 3'b000;
        sel_dur = '0;
`ifdef LAVANDERIA_VUELTO_EN
        // Highest affordable price wins; strict compare keeps it order-independent.
        best = '0;
        if (cnt_q >= P_SEC) begin
            sel  = 3'b001;
            best = P_SEC;
        end
        if (cnt_q >= P_LAV && P_LAV > best) begin
            sel  = 3'b010;
            best = P_LAV;
        end
        if (cnt_q >= P_PES && P_PES > best) begin
            sel  = 3'b100;
            best = P_PES;
        end
        sel_chg = cnt_q - best;
`else
        if (cnt_q == P_SEC) begin
            sel = 3'b001;
        end else if (cnt_q == P_LAV) begin
            sel = 3'b010;
        end else if (cnt_q == P_PES) begin
            sel = 3'b100;
        end
`endif
        case (sel)
            3'b001:  sel_dur = D_SEC;
            3'b010:  sel_dur = D_LAV;
            3'b100:  sel_dur = D_PES;
            default: sel_dur = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        svc_d   = svc_q;
        ins_d   = ins_q;
        ocu_d   = ocu_q;
`ifdef LAVANDERIA_VUELTO_EN
        vuelto_d = vuelto_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (intro_moneda) begin
                    cnt_d   = CNT_W'(1);
                    tmr_d   = '0;
                    state_d = S_COUNTING;
                end
            end
            S_COUNTING: begin
                if (intro_moneda) begin
                    cnt_d = cnt_inc;
                    tmr_d = '0;
                end
                if (cancelar) begin
                    state_d = S_REJECT;
                    ins_d   = 1'b1;
                    tmr_d   = D_INS;
                end else if (finalizar_pago) begin
                    state_d = S_VERIFY;
                    ocu_d   = 1'b1;
                end else if (!intro_moneda) begin
                    if (tmr_q == TMO_END) begin
                        state_d = S_REJECT;
                        ins_d   = 1'b1;
                        tmr_d   = D_INS;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
            end
            S_VERIFY: begin
                if (sel != 3'b000) begin
                    state_d = S_SERVICE;
                    svc_d   = sel;
                    tmr_d   = sel_dur;
`ifdef LAVANDERIA_VUELTO_EN
                    vuelto_d = sel_chg;
`endif
                end else begin
                    state_d = S_REJECT;
                    ins_d   = 1'b1;
                    ocu_d   = 1'b0;
                    tmr_d   = D_INS;
                end
            end
            S_SERVICE: begin
                if (tmr_q == '0) begin
                    state_d = S_IDLE;
                    svc_d   = 3'b000;
                    ocu_d   = 1'b0;
                    cnt_d   = '0;
`ifdef LAVANDERIA_VUELTO_EN
                    vuelto_d = '0;
`endif
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_REJECT: begin
                if (tmr_q == '0) begin
                    state_d = S_IDLE;
                    ins_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tmr_d   = '0;
                svc_d   = 3'b000;
                ins_d   = 1'b0;
                ocu_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tmr_q   <= '0;
            svc_q   <= 3'b000;
            ins_q   <= 1'b0;
            ocu_q   <= 1'b0;
`ifdef LAVANDERIA_VUELTO_EN
            vuelto_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            svc_q   <= svc_d;
            ins_q   <= ins_d;
            ocu_q   <= ocu_d;
`ifdef LAVANDERIA_VUELTO_EN
            vuelto_q <= vuelto_d;
`endif
        end
    end

    assign SECADO        = svc_q[0];
    assign LAVADO        = svc_q[1];
    assign LAVADO_PESADO = svc_q[2];
    assign insuficiente  = ins_q;
    assign ocupado       = ocu_q;
    assign monedas       = cnt_q;
`ifdef LAVANDERIA_VUELTO_EN
    assign vuelto        = vuelto_q;
`else
    assign vuelto        = '0;
`endif

endmodule

// File: tb/tb_lavanderia_param.sv
// Directed bench for lavanderia_param: expected pulses are queued at finalisation and
// checked (kind and length) by a negedge monitor; timing points use inline assertions.
module tb_lavanderia_param;

    localparam int K_SEC = 1;
    localparam int K_LAV = 2;
    localparam int K_PES = 3;
    localparam int K_INS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       intro_moneda;
    logic       finalizar_pago;
    logic       cancelar;
    logic       SECADO;
    logic       LAVADO;
    logic       LAVADO_PESADO;
    logic       insuficiente;
    logic       ocupado;
    logic [3:0] monedas;
    logic [3:0] vuelto;

    typedef struct {
        int kind;
        int len;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cur_kind = 0;
    int   cur_len = 0;

    lavanderia_param dut (
        .clk           (clk),
        .rst           (rst),
        .intro_moneda  (intro_moneda),
        .finalizar_pago(finalizar_pago),
        .cancelar      (cancelar),
        .SECADO        (SECADO),
        .LAVADO        (LAVADO),
        .LAVADO_PESADO (LAVADO_PESADO),
        .insuficiente  (insuficiente),
        .ocupado       (ocupado),
        .monedas       (monedas),
        .vuelto        (vuelto)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int len);
        exp_t e;
        e.kind = kind;
        e.len  = len;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            if (!(SECADO | LAVADO | LAVADO_PESADO | insuficiente | ocupado) && monedas == 4'd0)
                done = 1'b1;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {21'd0, SECADO, LAVADO, LAVADO_PESADO, insuficiente, ocupado, monedas, vuelto},
              32'd0);
    endtask

    // Pulse monitor: measures each output pulse and matches it against the scoreboard.
    always @(negedge clk) begin
        logic [3:0] vec;
        int         code;
        vec  = {insuficiente, LAVADO_PESADO, LAVADO, SECADO};
        code = 0;
        if (SECADO) code = K_SEC;
        else if (LAVADO) code = K_LAV;
        else if (LAVADO_PESADO) code = K_PES;
        else if (insuficiente) code = K_INS;
        if (rst) begin
            cur_kind = 0;
            cur_len  = 0;
        end else begin
            check("onehot_outputs", $countones(vec) <= 1, 32'd1);
            if (code != 0) begin
                if (cur_kind == 0) begin
                    cur_kind = code;
                    cur_len  = 1;
                end else begin
                    check("pulse_kind_stable", code, cur_kind);
                    cur_len++;
                end
            end else if (cur_kind != 0) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", cur_kind, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pulse_kind", cur_kind, e.kind);
                    check("pulse_len", cur_len, e.len);
                end
                cur_kind = 0;
                cur_len  = 0;
            end
        end
    end

    initial begin
        rst            = 1'b1;
        intro_moneda   = 1'b0;
        finalizar_pago = 1'b0;
        cancelar       = 1'b0;
        #2;
        check_all_zero("reset_outputs");
        tick();
        rst = 1'b0;

        // 3 coins -> SECADO, 3 cycles, rising two edges after finalizar
        intro_moneda = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sec_count", monedas, i + 1);
        end
        intro_moneda   = 1'b0;
        finalizar_pago = 1'b1;
        push(K_SEC, 3);
        tick();
        finalizar_pago = 1'b0;
        check("sec_verify_busy", ocupado, 32'd1);
        check("sec_verify_out", SECADO, 32'd0);
        tick();
        check("sec_rise", SECADO, 32'd1);
        check("sec_busy", ocupado, 32'd1);
        tick();
        tick();
        check("sec_last", SECADO, 32'd1);
        tick();
        check("sec_fall", SECADO, 32'd0);
        check("sec_idle_busy", ocupado, 32'd0);
        check("sec_idle_count", monedas, 32'd0);

        // 9 coins, last together with finalizar -> LAVADO_PESADO
        intro_moneda = 1'b1;
        repeat (8) tick();
        finalizar_pago = 1'b1;
        push(K_PES, 9);
        tick();
        intro_moneda   = 1'b0;
        finalizar_pago = 1'b0;
        check("pes_count", monedas, 32'd9);
        check("pes_busy", ocupado, 32'd1);
        wait_idle("pes_idle");

        // 5 coins: rejected, or LAVADO with change of 1
        intro_moneda = 1'b1;
        repeat (5) tick();
        intro_moneda   = 1'b0;
        finalizar_pago = 1'b1;
`ifdef LAVANDERIA_VUELTO_EN
        push(K_LAV, 4);
`else
        push(K_INS, 1);
`endif
        tick();
        finalizar_pago = 1'b0;
        tick();
`ifdef LAVANDERIA_VUELTO_EN
        check("five_lav", LAVADO, 32'd1);
        check("five_vuelto", vuelto, 32'd1);
`else
        check("five_ins", insuficiente, 32'd1);
        check("five_no_lav", LAVADO, 32'd0);
        check("five_vuelto", vuelto, 32'd0);
`endif
        wait_idle("five_idle");

        // 2 coins then inactivity timeout
        intro_moneda = 1'b1;
        repeat (2) tick();
        intro_moneda = 1'b0;
        push(K_INS, 1);
        repeat (15) tick();
        check("tmo_not_yet", insuficiente, 32'd0);
        check("tmo_count_held", monedas, 32'd2);
        tick();
        check("tmo_fire", insuficiente, 32'd1);
        check("tmo_not_busy", ocupado, 32'd0);
        wait_idle("tmo_idle");

        // cancelar wins over finalizar_pago
        intro_moneda = 1'b1;
        tick();
        intro_moneda   = 1'b0;
        cancelar       = 1'b1;
        finalizar_pago = 1'b1;
        push(K_INS, 1);
        tick();
        cancelar       = 1'b0;
        finalizar_pago = 1'b0;
        check("cancel_ins", insuficiente, 32'd1);
        check("cancel_not_verify", ocupado, 32'd0);
        wait_idle("cancel_idle");

        // 20 coins saturate at 15
        intro_moneda = 1'b1;
        repeat (20) tick();
        check("sat_count", monedas, 32'd15);
        intro_moneda   = 1'b0;
        finalizar_pago = 1'b1;
`ifdef LAVANDERIA_VUELTO_EN
        push(K_PES, 9);
`else
        push(K_INS, 1);
`endif
        tick();
        finalizar_pago = 1'b0;
        tick();
`ifdef LAVANDERIA_VUELTO_EN
        check("sat_vuelto", vuelto, 32'd6);
`else
        check("sat_vuelto", vuelto, 32'd0);
`endif
        wait_idle("sat_idle");

        // coins offered during VERIFY/SERVICE are ignored
        intro_moneda = 1'b1;
        repeat (4) tick();
        intro_moneda   = 1'b0;
        finalizar_pago = 1'b1;
        push(K_LAV, 4);
        tick();
        finalizar_pago = 1'b0;
        intro_moneda   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("svc_count_held", monedas, 32'd4);
        end
        intro_moneda = 1'b0;
        check("svc_lav_on", LAVADO, 32'd1);
        wait_idle("svc_idle");

        // async reset in the middle of LAVADO
        intro_moneda = 1'b1;
        repeat (4) tick();
        intro_moneda   = 1'b0;
        finalizar_pago = 1'b1;
        push(K_LAV, 4);
        tick();
        finalizar_pago = 1'b0;
        tick();
        tick();
        check("rst_pre_lav", LAVADO, 32'd1);
        #2;
        void'(sb.pop_front());
        rst = 1'b1;
        #1;
        check_all_zero("rst_async_outputs");
        @(negedge clk);
        tick();
        rst = 1'b0;
        intro_moneda = 1'b1;
        repeat (4) tick();
        intro_moneda   = 1'b0;
        finalizar_pago = 1'b1;
        push(K_LAV, 4);
        tick();
        finalizar_pago = 1'b0;
        tick();
        check("post_rst_lav", LAVADO, 32'd1);
        wait_idle("post_rst_idle");

        repeat (5) tick();
        check("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lavanderia_param.md
Name: lavanderia_param

Overview:
Parametrised coin-operated laundry controller, next generation of the Lavanderia payment FSM. Counts coins and, on finalisation, compares the total against three configurable service prices. Drives the matching service output for a configurable number of cycles, or raises an insufficient-payment pulse. Adds an inactivity timeout, cancellation, a busy flag, and optional change return; sits between the coin acceptor and the machine actuators.

Parameters:
CNT_W, 4, width of coin counter; prices must fit
PRICE_SEC, 3, coins for drying (SECADO)
PRICE_LAV, 4, coins for wash (LAVADO)
PRICE_PES, 9, coins for heavy wash (LAVADO_PESADO)
T_SEC, 3, SECADO pulse length in clk cycles (>=1)
T_LAV, 4, LAVADO pulse length in cycles (>=1)
T_PES, 9, LAVADO_PESADO pulse length in cycles (>=1)
T_INS, 1, insuficiente pulse length in cycles (>=1)
TIMEOUT, 16, idle cycles in COUNTING before auto-abort (>=2)

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  asynchronous reset, active-high
intro_moneda  in  1  one coin per cycle high
finalizar_pago  in  1  end-of-payment request
cancelar  in  1  abort current payment
SECADO  out  1  drying service active
LAVADO  out  1  wash service active
LAVADO_PESADO  out  1  heavy wash active
insuficiente  out  1  payment rejected/aborted pulse
ocupado  out  1  high in VERIFY and SERVICE
monedas  out  CNT_W  current coin count
vuelto  out  CNT_W  change owed (0 unless LAVANDERIA_VUELTO_EN)

Behaviour:
- Reset (async, immediate): state IDLE; count, timer, vuelto = 0; all service outputs, insuficiente, ocupado = 0. Reset mid-service drops outputs at once.
- States: IDLE, COUNTING, VERIFY, SERVICE, REJECT.
- IDLE: intro_moneda -> count=1, COUNTING. finalizar_pago/cancelar ignored.
- COUNTING: each intro_moneda cycle increments count, saturating at 2^CNT_W-1; timer cleared on any coin. finalizar_pago -> VERIFY. Same-cycle coin+finalizar: coin counted first, VERIFY sees updated count. cancelar (priority over finalizar_pago) -> REJECT. Timer reaching TIMEOUT with no coin/finalizar -> REJECT.
- VERIFY (one cycle): exact match count==PRICE_SEC/LAV/PES selects service, loads duration, -> SERVICE; otherwise -> REJECT. Service output rises on edge after VERIFY (2 edges after finalizar_pago sampled).
- SERVICE: selected output high exactly T_x cycles, then IDLE, count=0. Exactly one service output high at a time.
- REJECT: insuficiente high exactly T_INS cycles, then IDLE, count=0.
- Coins, finalizar_pago, cancelar ignored in VERIFY/SERVICE/REJECT; monedas holds value until return to IDLE.
- Elaboration check: prices distinct, nonzero, < 2^CNT_W; violation is a fatal error.

Optional Feature:
LAVANDERIA_VUELTO_EN: defined -> VERIFY selects highest-priced service with price <= count; vuelto = count - price, registered in VERIFY, held through SERVICE, cleared on return to IDLE; insuficiente only when count < smallest price. Undefined -> exact-match only, vuelto tied to 0.

Test Plan:
- 3 coins, finalizar_pago -> SECADO high 3 cycles starting 2 edges after finalizar; ocupado high VERIFY+SERVICE; then IDLE, monedas=0.
- 9 coins with last coin same cycle as finalizar_pago -> LAVADO_PESADO high 9 cycles.
- 5 coins, finalizar_pago (macro off) -> insuficiente 1 cycle, no service output; (macro on) -> LAVADO 4 cycles, vuelto=1.
- 2 coins then 16 idle cycles -> insuficiente pulse, IDLE; cancelar+finalizar same cycle -> REJECT.
- 20 coins with CNT_W=4 -> monedas saturates at 15; coins during SERVICE do not change monedas.
- rst asserted mid LAVADO pulse -> all outputs 0 immediately, no clk edge required; next 4 coins+finalizar -> normal LAVADO.
